uart_tx_periph: RTL

Sequencer-driven serial transmit peripheral that sits directly downstream of the sequencer's output-register bus, alongside the DDR controller, LED bank and switch peripherals. It decodes 12-bit instructions from one oreg_wen lane and buffers bytes in a small FIFO. It serialises each byte as 8N1 UART frames on tx. Its ready output goes back to a sequencer input register, so microcode can poll before pushing.

---
 rtl/uart_tx_periph.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_periph.sv
// Sequencer-driven 8N1 UART transmitter: decodes 12-bit instructions, queues bytes in a FIFO, serialises them on tx.
// State table -- IDLE: line high, pop when queued | START: start bit | DATA: 8 bits LSB first | STOP: stop bit
module uart_tx_periph #(
  parameter int          FIFO_LOG  = 3,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] inst,
  input  logic        inst_en,
  output logic        tx,
  output logic        ready,
  output logic        busy,
  output logic        overflow
);

  localparam int DEPTH = 1 << FIFO_LOG;
  localparam logic [FIFO_LOG:0] FULL_CNT = {1'b1, {FIFO_LOG{1'b0}}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [3:0]           opcode;
  logic [7:0]           imm;
  logic                 push_req, clear, div_lo_wr, div_hi_wr;
  logic [7:0]           mem [DEPTH];
  logic [FIFO_LOG-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_LOG:0]    count_q, count_d;
  logic                 full, pop, push_ok, bit_end, tx_d;
  logic [15:0]          div_q, per_q, cnt_q;
  logic [2:0]           bit_idx_q;
  logic [7:0]           shift_q;

  assign opcode    = inst[11:8];
  assign imm       = inst[7:0];
  assign push_req  = inst_en && (opcode == 4'd1);
  assign div_lo_wr = inst_en && (opcode == 4'd2);
  assign div_hi_wr = inst_en && (opcode == 4'd3);
  assign clear     = inst_en && (opcode == 4'd4);

  assign full    = (count_q == FULL_CNT);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push_req && (!full || pop);
  assign bit_end = (state_q != IDLE) && (cnt_q == per_q - 16'd1);

  assign ready = (count_q != FULL_CNT);
  assign busy  = (state_q != IDLE) || (count_q != '0);

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_end && (bit_idx_q == 3'd7)) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (push_ok && !pop)
      count_d = count_q + (FIFO_LOG+1)'(1);
    else if (pop && !push_ok)
      count_d = count_q - (FIFO_LOG+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (push_ok && !clear) mem[wr_ptr] <= imm;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      count_q <= count_d;
      // CLEAR beats a simultaneous pop; the popped byte is already in the shifter.
      if (clear) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + FIFO_LOG'(1);
        if (pop)     rd_ptr <= rd_ptr + FIFO_LOG'(1);
        if (push_req && !push_ok) overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_q <= DIV_RESET;
    end else begin
      if (div_lo_wr) div_q[7:0]  <= imm;
      if (div_hi_wr) div_q[15:8] <= imm;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx        <= 1'b1;
      cnt_q     <= '0;
      per_q     <= 16'd2;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q <= state_d;
      tx      <= tx_d;
      if ((state_q == IDLE) || bit_end)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 16'd1;
      if (pop) begin
        shift_q <= mem[rd_ptr];
        per_q   <= (div_q < 16'd2) ? 16'd2 : div_q;
      end else if ((state_q == DATA) && bit_end) begin
        shift_q <= {1'b0, shift_q[7:1]};
      end
      if (state_q == START)
        bit_idx_q <= '0;
      else if ((state_q == DATA) && bit_end)
        bit_idx_q <= bit_idx_q + 3'd1;
    end
  end

endmodule
